// File: rtl/memory_router_pkg.sv
// Shared router types and default address map for memory_router.
// Optional feature macro used by the top: MEMORY_ROUTER_TIMEOUT_EN.
package configure;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_ERROR = 2'd2
   } router_state_e;

   localparam int DEFAULT_NUM_SLAVES = 4;

   // Slave 0 occupies the least significant 32-bit lane.
   localparam logic [127:0] DEFAULT_SLAVE_BASE = {
      32'h2000_0000, 32'h1000_0000, 32'h0200_0000, 32'h0000_0000
   };
   localparam logic [127:0] DEFAULT_SLAVE_TOP = {
      32'h2001_0000, 32'h1000_1000, 32'h0200_C000, 32'h0010_0000
   };

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Wait counter is kept between 8 and 16 bits wide.
   function automatic int cnt_width(input int t);
      int w;
      w = $clog2(t + 1);
      if (w < 8) begin
         w = 8;
      end else if (w > 16) begin
         w = 16;
      end else begin
         w = w;
      end
      return w;
   endfunction

endpackage

// File: rtl/memory_router_decode.sv
// Address window decoder: per-slave hit vector, lowest-index priority pick, hit flag.
module memory_router_decode
   import configure::*;
#(
   parameter int                         NUM_SLAVES = DEFAULT_NUM_SLAVES,
   parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE = DEFAULT_SLAVE_BASE,
   parameter logic [NUM_SLAVES*32-1:0]   SLAVE_TOP  = DEFAULT_SLAVE_TOP,
   parameter int                         IW         = idx_width(NUM_SLAVES)
) (
   input  logic [31:0]           addr,
   output logic [NUM_SLAVES-1:0] hit_vec,
   output logic [IW-1:0]         idx,
   output logic                  hit
);

   // Window compare: base inclusive, top exclusive.
   always_comb begin
      hit_vec = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if ((addr >= SLAVE_BASE[i*32 +: 32]) && (addr < SLAVE_TOP[i*32 +: 32])) begin
            hit_vec[i] = 1'b1;
         end else begin
            hit_vec[i] = 1'b0;
         end
      end
   end

   // Scan high to low so the lowest matching index is the one left standing.
   always_comb begin
      idx = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if (hit_vec[i]) begin
            idx = IW'(i);
         end else begin
            idx = idx;
         end
      end
   end

   assign hit = |hit_vec;

endmodule

// File: rtl/memory_router.sv
// Single-outstanding address router from one arbiter port to NUM_SLAVES slaves.
// Define MEMORY_ROUTER_TIMEOUT_EN to enable the BUSY wait-counter timeout.
module memory_router
   import configure::*;
#(
   parameter int                         NUM_SLAVES = DEFAULT_NUM_SLAVES,
   parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE = DEFAULT_SLAVE_BASE,
   parameter logic [NUM_SLAVES*32-1:0]   SLAVE_TOP  = DEFAULT_SLAVE_TOP,
   parameter int                         TIMEOUT    = 255
) (
   input  logic                       reset,
   input  logic                       clock,
   input  logic                       memory_valid,
   input  logic                       memory_instr,
   input  logic [31:0]                memory_addr,
   input  logic [31:0]                memory_wdata,
   input  logic [3:0]                 memory_wstrb,
   output logic [31:0]                memory_rdata,
   output logic                       memory_ready,
   output logic                       memory_error,
   output logic [NUM_SLAVES-1:0]      slave_valid,
   output logic                       slave_instr,
   output logic [31:0]                slave_addr,
   output logic [31:0]                slave_wdata,
   output logic [3:0]                 slave_wstrb,
   input  logic [NUM_SLAVES*32-1:0]   slave_rdata,
   input  logic [NUM_SLAVES-1:0]      slave_ready
);

   localparam int IW = idx_width(NUM_SLAVES);

   router_state_e          state_q, state_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [NUM_SLAVES-1:0]  dec_hit_vec_s;
   logic [IW-1:0]          dec_idx_s;
   logic                   dec_hit_s;
   logic [NUM_SLAVES-1:0]  slave_valid_s;
   logic                   ready_s;
   logic                   error_s;
   logic [31:0]            rdata_s;

`ifdef MEMORY_ROUTER_TIMEOUT_EN
   localparam int CW = cnt_width(TIMEOUT);
   logic [CW-1:0]          cnt_q, cnt_d;
`endif

   memory_router_decode #(
      .NUM_SLAVES (NUM_SLAVES),
      .SLAVE_BASE (SLAVE_BASE),
      .SLAVE_TOP  (SLAVE_TOP),
      .IW         (IW)
   ) u_decode (
      .addr    (memory_addr),
      .hit_vec (dec_hit_vec_s),
      .idx     (dec_idx_s),
      .hit     (dec_hit_s)
   );

   // Next-state and response logic; responses are forwarded in the slave's own cycle.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      slave_valid_s = '0;
      ready_s       = 1'b0;
      error_s       = 1'b0;
      rdata_s       = 32'h0000_0000;
`ifdef MEMORY_ROUTER_TIMEOUT_EN
      cnt_d         = cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (memory_valid) begin
               if (dec_hit_s && dec_hit_vec_s[dec_idx_s]) begin
                  slave_valid_s[dec_idx_s] = 1'b1;
                  if (slave_ready[dec_idx_s]) begin
                     ready_s = 1'b1;
                     rdata_s = slave_rdata[dec_idx_s*32 +: 32];
                  end else begin
                     state_d = ST_BUSY;
                     idx_d   = dec_idx_s;
`ifdef MEMORY_ROUTER_TIMEOUT_EN
                     cnt_d   = '0;
`endif
                  end
               end else begin
                  state_d = ST_ERROR;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (slave_ready[idx_q]) begin
               ready_s = 1'b1;
               rdata_s = slave_rdata[idx_q*32 +: 32];
               state_d = ST_IDLE;
            end else begin
`ifdef MEMORY_ROUTER_TIMEOUT_EN
               // cnt_q holds completed silent BUSY cycles; this is the TIMEOUT-th.
               if (cnt_q >= CW'(TIMEOUT - 1)) begin
                  ready_s = 1'b1;
                  error_s = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
`else
               state_d = ST_BUSY;
`endif
            end
         end
         ST_ERROR: begin
            ready_s = 1'b1;
            error_s = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (!reset) begin
         slave_valid_s = '0;
         ready_s       = 1'b0;
         error_s       = 1'b0;
         rdata_s       = 32'h0000_0000;
         state_d       = ST_IDLE;
      end else begin
         state_d       = state_d;
      end
   end

   // Router state, latched slave index and optional wait counter.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
`ifdef MEMORY_ROUTER_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
`ifdef MEMORY_ROUTER_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign slave_valid  = slave_valid_s;
   assign memory_ready = ready_s;
   assign memory_error = error_s;
   assign memory_rdata = rdata_s;
   assign slave_instr  = memory_instr;
   assign slave_wdata  = memory_wdata;
   assign slave_wstrb  = memory_wstrb;
   assign slave_addr   = dec_hit_s ? (memory_addr - SLAVE_BASE[dec_idx_s*32 +: 32]) : memory_addr;

endmodule

// File: doc/memory_router.md
MEMORY_ROUTER -- requirements
Module: memory_router

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 4: number of slave ports, range 1..16.
REQ-002 SHALL have parameter SLAVE_BASE, default {0x00000000,0x02000000,0x10000000,0x20000000}: per-slave inclusive base address.
REQ-003 SHALL have parameter SLAVE_TOP, default {0x00100000,0x0200C000,0x10001000,0x20010000}: per-slave exclusive top address.
REQ-004 SHALL have parameter TIMEOUT, default 255: maximum number of wait cycles per transaction.
REQ-005 SHALL have these ports, one per line (name direction width meaning):
 reset  in  1  synchronous, active-low
 clock  in  1  rising-edge clock
 memory_valid  in  1  one-cycle request pulse from arbiter
 memory_instr  in  1  instruction-fetch flag
 memory_addr  in  32  absolute byte address
 memory_wdata  in  32  write data
 memory_wstrb  in  4  byte strobes; all zero means read
 memory_rdata  out  32  response data
 memory_ready  out  1  one-cycle response pulse
 memory_error  out  1  valid with memory_ready; decode miss or timeout
 slave_valid  out  NUM_SLAVES  per-slave request pulse
 slave_instr  out  1  broadcast copy of memory_instr
 slave_addr  out  32  memory_addr minus the selected SLAVE_BASE
 slave_wdata  out  32  broadcast write data
 slave_wstrb  out  4  broadcast byte strobes
 slave_rdata  in  NUM_SLAVES x 32  per-slave read data
 slave_ready  in  NUM_SLAVES  per-slave response pulse

Function
REQ-006 Decode: the selected slave SHALL be the lowest index i with SLAVE_BASE[i] <= memory_addr < SLAVE_TOP[i]; overlapping windows resolve to the lower index.
REQ-007 FSM states SHALL be IDLE, BUSY and ERROR.
REQ-008 In IDLE, on memory_valid with a decode hit, slave_valid[i] SHALL assert combinationally in the same cycle; the FSM SHALL latch i and go to BUSY.
REQ-009 In IDLE, on memory_valid with a decode miss, no slave_valid SHALL assert and the FSM SHALL go to ERROR.
REQ-010 In ERROR (one cycle), memory_ready=1, memory_error=1 and memory_rdata=0 SHALL be driven; the FSM SHALL then return to IDLE (decode-miss latency: 1 cycle).
REQ-011 If slave_ready[i] is asserted in the same cycle as the request, the response SHALL be forwarded that cycle and the FSM SHALL stay in IDLE (zero-latency slave).
REQ-012 In BUSY, memory_ready and memory_rdata SHALL equal slave_ready and slave_rdata of the latched index only; when memory_ready is 1, the FSM SHALL return to IDLE.
REQ-013 A slave_ready from any non-selected slave, or any slave_ready while in IDLE with no request, SHALL be ignored.
REQ-014 memory_valid received in BUSY or ERROR SHALL be dropped: no slave_valid and no response.
REQ-015 memory_rdata SHALL be 0 whenever memory_ready is 0.

Reset
REQ-016 While reset=0 at a rising clock edge, the FSM SHALL enter IDLE and the wait counter SHALL clear.
REQ-017 During reset, memory_ready, memory_error, memory_rdata and slave_valid SHALL all be 0.
REQ-018 A transaction in flight at reset SHALL be abandoned, and its late slave_ready SHALL be ignored.

Configuration
REQ-019 With macro MEMORY_ROUTER_TIMEOUT_EN defined, an 8..16-bit wait counter SHALL count BUSY cycles.
REQ-020 With MEMORY_ROUTER_TIMEOUT_EN defined, when the counter reaches TIMEOUT without slave_ready, the block SHALL drive memory_ready=1, memory_error=1 and memory_rdata=0, and return to IDLE.
REQ-021 With MEMORY_ROUTER_TIMEOUT_EN defined, a slave_ready arriving in the same cycle as the timeout SHALL win and be forwarded with memory_error=0.
REQ-022 Without MEMORY_ROUTER_TIMEOUT_EN, BUSY SHALL wait indefinitely, and memory_error SHALL assert only on a decode miss.

Structure
REQ-023 The router state enum typedef and the default base/top address constants SHALL live in package configure.
REQ-024 Address decode (hit vector, priority index, hit flag) SHALL be a sub-module named memory_router_decode.

Verification
REQ-025 Read at 0x00000040, slave0 ready 1 cycle later with rdata 0xDEADBEEF -> slave_valid=0001, slave_addr=0x40, then memory_ready=1, memory_rdata=0xDEADBEEF, memory_error=0.
REQ-026 Write to 0x02004000 with wstrb=1111 -> slave_valid=0010, slave_addr=0x4000, wdata and wstrb passed through unchanged.
REQ-027 Access to 0x30000000 -> no slave_valid, then next cycle memory_ready=1, memory_error=1, memory_rdata=0.
REQ-028 With timeout enabled and TIMEOUT=8, slave2 silent -> error response after 8 BUSY cycles; slave2 ready at cycle 12 -> ignored.
REQ-029 While BUSY on slave0, slave1 ready pulse and a new memory_valid -> both ignored; slave0 response is still delivered correctly.
REQ-030 reset=0 asserted mid-BUSY, then released -> all outputs 0 and state IDLE; a subsequent access completes normally.
